// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package seq_restoring_divider_pkg;

  localparam int DEF_DIVIDEND_W = 50;
  localparam int DEF_DIVISOR_W  = 34;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_subtractor.sv
// Unsigned ripple-borrow subtractor: diff = a - b, borrow set when b > a.
module unsigned_ripple_subtractor
  import seq_restoring_divider_pkg::*;
#(
  parameter int W = DEF_DIVISOR_W + 1
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff,
  output logic         borrow
);

  logic [W:0] chain;

  always_comb begin
    chain = '0;
    diff  = '0;
    for (int i = 0; i < W; i++) begin
      diff[i]      = a[i] ^ b[i] ^ chain[i];
      chain[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & chain[i]);
    end
  end

  assign borrow = chain[W];

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle,
// valid/ready handshake on both the operand and the result side.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int               CNT_W    = cnt_width(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] shreg;    // dividend bits leave at the MSB, quotient bits enter at the LSB
  logic [DIVISOR_W:0]    rem_r;
  logic [DIVISOR_W-1:0]  div_r;

  logic [DIVISOR_W:0] trial;
  logic [DIVISOR_W:0] diff;
  logic [DIVISOR_W:0] rem_nxt;
  logic               borrow;
  logic               qbit;
  logic               accept;
  logic               last;
  logic               retire;
  logic               zero_div;
  logic               r_msb_unused;

  // The top bit of R is provably zero after every step, so only the low bits feed the trial.
  assign trial        = {rem_r[DIVISOR_W-1:0], shreg[DIVIDEND_W-1]};
  assign r_msb_unused = rem_r[DIVISOR_W];
  assign zero_div     = (divisor == '0);

  unsigned_ripple_subtractor #(
    .W(DIVISOR_W + 1)
  ) u_sub (
    .a      (trial),
    .b      ({1'b0, div_r}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign qbit    = ~borrow;
  assign rem_nxt = borrow ? trial : diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    retire    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_nxt = zero_div ? DONE : CALC;
      end
      CALC: begin
        last = (count == '0);
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        retire    = out_ready;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and result registers: cleared by reset, results only change when a new one lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      count <= CNT_LAST;
      if (zero_div) begin
        quotient    <= '1;
        remainder   <= '0;
        div_by_zero <= 1'b1;
      end
    end else if (state == CALC) begin
      if (last) begin
        quotient    <= {shreg[DIVIDEND_W-2:0], qbit};
        remainder   <= rem_nxt[DIVISOR_W-1:0];
        div_by_zero <= 1'b0;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

  // Working datapath: always loaded on accept before use, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= dividend;
      div_r <= divisor;
      rem_r <= '0;
    end else if (state == CALC) begin
      shreg <= {shreg[DIVIDEND_W-2:0], qbit};
      rem_r <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised checks of the sequential restoring divider.
module tb_seq_restoring_divider;

  localparam int DW = 50;
  localparam int VW = 34;
  localparam logic [63:0] ONES50 = 64'h0003_FFFF_FFFF_FFFF;
  localparam logic [63:0] ONES34 = 64'h0000_0003_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] dividend = '0;
  logic [VW-1:0] divisor = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int n_checks = 0;
  int n_fail   = 0;

  seq_restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operation and returns #1 after the accept edge.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("in_ready_before_accept", {63'd0, in_ready}, 64'd1);
    dividend = a[DW-1:0];
    divisor  = b[VW-1:0];
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = ~a[DW-1:0];
    divisor  = ~b[VW-1:0];
  endtask

  // Counts rising edges after the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic retire(input string tag, input logic [63:0] exp_q);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
    check({tag, "_ready_back"}, {63'd0, in_ready}, 64'd1);
    check({tag, "_q_kept"}, {14'd0, quotient}, exp_q);
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_q, input logic [63:0] exp_r,
                        input logic exp_z, input int exp_lat);
    int lat;
    start_op(a, b);
    wait_result(lat);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, {14'd0, quotient}, exp_q);
    check({tag, "_r"}, {30'd0, remainder}, exp_r);
    check({tag, "_dbz"}, {63'd0, div_by_zero}, {63'd0, exp_z});
    retire(tag, exp_q);
  endtask

  initial begin
    int lat;
    logic [63:0] ra, rb, rq, rr;

    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_q", {14'd0, quotient}, 64'd0);
    check("rst_r", {30'd0, remainder}, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op("div_100_7", 64'd100, 64'd7, 64'd14, 64'd2, 1'b0, 50);
    run_op("max_by_1", ONES50, 64'd1, ONES50, 64'd0, 1'b0, 50);
    // (2^34-1)*2^16 = 2^50-2^16, leaving 2^16-1
    run_op("max_by_max", ONES50, ONES34, 64'd65536, 64'd65535, 1'b0, 50);
    run_op("div_5_9", 64'd5, 64'd9, 64'd0, 64'd5, 1'b0, 50);
    run_op("div_0_3", 64'd0, 64'd3, 64'd0, 64'd0, 1'b0, 50);
    run_op("div_123_0", 64'd123, 64'd0, ONES50, 64'd0, 1'b1, 0);
    run_op("after_dbz", 64'd9, 64'd4, 64'd2, 64'd1, 1'b0, 50);

    // Backpressure: result held for 10 cycles while another op is offered.
    start_op(64'd200, 64'd7);
    wait_result(lat);
    check("hold_latency", 64'(lat), 64'd50);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      dividend = 50'd999;
      divisor  = 34'd3;
      @(posedge clk);
      #1;
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_q", {14'd0, quotient}, 64'd28);
      check("hold_r", {30'd0, remainder}, 64'd4);
    end
    @(negedge clk);
    in_valid = 1'b0;
    retire("hold", 64'd28);
    @(posedge clk);
    #1;
    check("held_op_ignored", {63'd0, out_valid}, 64'd0);
    check("held_op_idle", {63'd0, in_ready}, 64'd1);

    // Asynchronous reset in the middle of a calculation.
    start_op(64'd77777, 64'd5);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_q", {14'd0, quotient}, 64'd0);
    check("mid_rst_r", {30'd0, remainder}, 64'd0);
    check("mid_rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("div_1000_33", 64'd1000, 64'd33, 64'd30, 64'd10, 1'b0, 50);

    // Back-to-back random operations against the arithmetic reference.
    for (int k = 0; k < 8; k++) begin
      ra = {$urandom, $urandom} & ONES50;
      rb = ({$urandom, $urandom} & ONES34) >> $urandom_range(0, 30);
      if (rb == 64'd0) rb = 64'd1;
      rq = ra / rb;
      rr = ra % rb;
      run_op("rnd", ra, rb, rq, rr, 1'b0, 50);
      check("rnd_invariant", {14'd0, quotient} * rb + {30'd0, remainder}, ra);
      check("rnd_rem_lt_div", {63'd0, ({30'd0, remainder} < rb)}, 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
